pipe_sel_reg: RTL and testbench

- Parametrised N-way selector with a registered output; successor to the fixed 2/4-way 6-bit combinational muxes.
- Used at P5 pipeline stage boundaries: selects an operand among forwarding sources and captures it into the next stage register.
- Supports stall (hold), flush (bubble insert), a valid bit, and a sticky illegal-select flag.
- A combinational tap of the selected value is also exported for same-cycle consumers.

---
 rtl/pipe_sel_reg.sv | 88 ++++++++
 tb/tb_pipe_sel_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_reg.sv
// N-way operand selector with a registered pipeline-stage output.
// Selects one of NUM_SRC forwarding sources. The selected value is exported
// combinationally and is also captured into a stage register. The stage
// register supports stall (hold), flush (bubble), a valid bit, a sticky
// illegal-select flag and a saturating count of consecutive stalled cycles.
module pipe_sel_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_SRC   = 4,
  parameter int unsigned      SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic                     valid_in,
  input  logic                     en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         comb_out,
  output logic [WIDTH-1:0]         q,
  output logic                     valid_out,
  output logic                     sel_err,
  output logic [7:0]               stall_cnt
);

  logic             sel_legal;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic [7:0]       stall_q, stall_d;

  // Source select: out-of-range indices produce zero and flag as illegal.
  // When NUM_SRC fills the whole select space every index matches, so the
  // illegal case never arises.
  always_comb begin
    comb_out  = '0;
    sel_legal = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        comb_out  = src[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  // Next-state: flush beats enable, enable beats stall.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    stall_d = stall_q;
    if (flush) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
      stall_d = '0;
    end else if (en) begin
      data_d  = comb_out;
      valid_d = valid_in;
      stall_d = '0;
      if (valid_in && !sel_legal) begin
        err_d = 1'b1;
      end
    end else if (stall_q != '1) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // Stage register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign q         = data_q;
  assign valid_out = valid_q;
  assign sel_err   = err_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Bench for pipe_sel_reg: three parameterisations run side by side against a
// rule-based reference model, with directed scenarios followed by random traffic.
module tb_pipe_sel_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0: defaults (WIDTH 32, 4 sources, SEL_W 2, RESET_VAL 0)
  logic         rst0, vi0, en0, fl0, v0, e0;
  logic [1:0]   sel0;
  logic [127:0] src0;
  logic [31:0]  co0, q0;
  logic [7:0]   sc0;
  // Instance 1: 3 sources in a 2-bit select space, nonzero reset value
  logic         rst1, vi1, en1, fl1, v1, e1;
  logic [1:0]   sel1;
  logic [95:0]  src1;
  logic [31:0]  co1, q1;
  logic [7:0]   sc1;
  // Instance 2: WIDTH 6, 2 sources, SEL_W 1
  logic         rst2, vi2, en2, fl2, v2, e2;
  logic [0:0]   sel2;
  logic [11:0]  src2;
  logic [5:0]   co2, q2;
  logic [7:0]   sc2;

  pipe_sel_reg u0 (
    .clk(clk), .reset(rst0), .sel(sel0), .src(src0), .valid_in(vi0), .en(en0),
    .flush(fl0), .comb_out(co0), .q(q0), .valid_out(v0), .sel_err(e0), .stall_cnt(sc0)
  );

  pipe_sel_reg #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .RESET_VAL(32'h5A5A_0000)) u1 (
    .clk(clk), .reset(rst1), .sel(sel1), .src(src1), .valid_in(vi1), .en(en1),
    .flush(fl1), .comb_out(co1), .q(q1), .valid_out(v1), .sel_err(e1), .stall_cnt(sc1)
  );

  pipe_sel_reg #(.WIDTH(6), .NUM_SRC(2), .SEL_W(1), .RESET_VAL(6'h00)) u2 (
    .clk(clk), .reset(rst2), .sel(sel2), .src(src2), .valid_in(vi2), .en(en2),
    .flush(fl2), .comb_out(co2), .q(q2), .valid_out(v2), .sel_err(e2), .stall_cnt(sc2)
  );

  // Stimulus state per instance
  int unsigned s_sel [3];
  logic [31:0] s_src [3][4];
  logic        s_rst [3];
  logic        s_fl  [3];
  logic        s_en  [3];
  logic        s_vi  [3];

  // Instance configuration as seen by the model
  int unsigned nsrc [3] = '{4, 3, 2};
  int unsigned selw [3] = '{2, 2, 1};
  logic [31:0] mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_003F};
  logic [31:0] rv   [3] = '{32'h0, 32'h5A5A_0000, 32'h0};

  // Reference model state
  logic [31:0] m_q  [3];
  logic        m_v  [3];
  logic        m_e  [3];
  int unsigned m_sc [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mcomb(input int i);
    if (s_sel[i] < nsrc[i]) return s_src[i][s_sel[i]] & mask[i];
    return 32'h0;
  endfunction

  task automatic set(input int i, input logic rst, input logic fl, input logic en,
                     input logic vi, input int unsigned sel);
    s_rst[i] = rst; s_fl[i] = fl; s_en[i] = en; s_vi[i] = vi; s_sel[i] = sel;
  endtask

  task automatic apply();
    rst0 = s_rst[0]; fl0 = s_fl[0]; en0 = s_en[0]; vi0 = s_vi[0]; sel0 = 2'(s_sel[0]);
    src0 = {s_src[0][3], s_src[0][2], s_src[0][1], s_src[0][0]};
    rst1 = s_rst[1]; fl1 = s_fl[1]; en1 = s_en[1]; vi1 = s_vi[1]; sel1 = 2'(s_sel[1]);
    src1 = {s_src[1][2], s_src[1][1], s_src[1][0]};
    rst2 = s_rst[2]; fl2 = s_fl[2]; en2 = s_en[2]; vi2 = s_vi[2]; sel2 = 1'(s_sel[2]);
    src2 = {s_src[2][1][5:0], s_src[2][0][5:0]};
  endtask

  // Model: one rising edge, applying the register rules in priority order.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (s_rst[i]) begin
        m_q[i] = rv[i]; m_v[i] = 1'b0; m_e[i] = 1'b0; m_sc[i] = 0;
      end else if (s_fl[i]) begin
        m_q[i] = rv[i]; m_v[i] = 1'b0; m_sc[i] = 0;
      end else if (s_en[i]) begin
        m_q[i] = mcomb(i); m_v[i] = s_vi[i]; m_sc[i] = 0;
        if (s_vi[i] && s_sel[i] >= nsrc[i]) m_e[i] = 1'b1;
      end else begin
        m_sc[i] = (m_sc[i] < 255) ? m_sc[i] + 1 : 255;
      end
    end
  endtask

  // One cycle: drive, check combinational taps, clock, check registers.
  task automatic step();
    apply();
    #1;
    chk("u0_comb", co0, mcomb(0));
    chk("u1_comb", co1, mcomb(1));
    chk("u2_comb", {26'b0, co2}, mcomb(2));
    @(posedge clk);
    #1;
    model_edge();
    chk("u0_q", q0, m_q[0]);   chk("u0_valid", {31'b0, v0}, {31'b0, m_v[0]});
    chk("u0_err", {31'b0, e0}, {31'b0, m_e[0]}); chk("u0_stall", {24'b0, sc0}, m_sc[0]);
    chk("u1_q", q1, m_q[1]);   chk("u1_valid", {31'b0, v1}, {31'b0, m_v[1]});
    chk("u1_err", {31'b0, e1}, {31'b0, m_e[1]}); chk("u1_stall", {24'b0, sc1}, m_sc[1]);
    chk("u2_q", {26'b0, q2}, m_q[2]); chk("u2_valid", {31'b0, v2}, {31'b0, m_v[2]});
    chk("u2_err", {31'b0, e2}, {31'b0, m_e[2]}); chk("u2_stall", {24'b0, sc2}, m_sc[2]);
    @(negedge clk);
  endtask

  initial begin
    s_src[0] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
    for (int i = 1; i < 3; i++)
      for (int k = 0; k < 4; k++) s_src[i][k] = $urandom;
    for (int i = 0; i < 3; i++) set(i, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Reset all instances
    step();
    chk("rst_q0", q0, 32'h0);
    chk("rst_q1", q1, 32'h5A5A_0000);
    chk("rst_stall0", {24'b0, sc0}, 32'd0);
    for (int i = 0; i < 3; i++) set(i, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Load source 2 with valid, comb tap visible before the edge
    set(0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    apply(); #1;
    chk("tp_comb_sel2", co0, 32'hCCCC_0002);
    step();
    chk("tp_load_q", q0, 32'hCCCC_0002);
    chk("tp_load_valid", {31'b0, v0}, 32'd1);

    // Load source 1, then stall three edges while sel sweeps
    set(0, 1'b0, 1'b0, 1'b1, 1'b1, 1); step();
    for (int k = 1; k <= 3; k++) begin
      set(0, 1'b0, 1'b0, 1'b0, 1'b1, k);
      step();
      chk("tp_stall_q", q0, 32'hBBBB_0001);
      chk("tp_stall_cnt", {24'b0, sc0}, k);
    end
    set(0, 1'b0, 1'b0, 1'b1, 1'b1, 0); step();
    chk("tp_resume_q", q0, 32'hAAAA_0000);
    chk("tp_resume_cnt", {24'b0, sc0}, 32'd0);

    // Flush against enable, then against stall
    set(0, 1'b0, 1'b1, 1'b1, 1'b1, 3); step();
    chk("tp_flush_en_q", q0, 32'h0);
    chk("tp_flush_en_valid", {31'b0, v0}, 32'd0);
    set(0, 1'b0, 1'b0, 1'b1, 1'b1, 3); step();
    set(0, 1'b0, 1'b0, 1'b0, 1'b1, 3); step(); step();
    set(0, 1'b0, 1'b1, 1'b0, 1'b1, 3); step();
    chk("tp_flush_stall_q", q0, 32'h0);
    chk("tp_flush_stall_cnt", {24'b0, sc0}, 32'd0);

    // Illegal select on the 3-source instance
    set(1, 1'b0, 1'b0, 1'b1, 1'b0, 3); step();
    chk("tp_ill_noval_comb", co1, 32'h0);
    chk("tp_ill_noval_q", q1, 32'h0);
    chk("tp_ill_noval_err", {31'b0, e1}, 32'd0);
    set(1, 1'b0, 1'b0, 1'b0, 1'b1, 3); step();
    chk("tp_ill_stall_err", {31'b0, e1}, 32'd0);
    set(1, 1'b0, 1'b1, 1'b1, 1'b1, 3); step();
    chk("tp_ill_flush_err", {31'b0, e1}, 32'd0);
    set(1, 1'b0, 1'b0, 1'b1, 1'b1, 3); step();
    chk("tp_ill_set_err", {31'b0, e1}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      set(1, 1'b0, 1'b0, 1'b1, 1'b1, k % 3); step();
    end
    chk("tp_ill_sticky", {31'b0, e1}, 32'd1);
    set(1, 1'b1, 1'b0, 1'b1, 1'b1, 0); step();
    chk("tp_ill_reset", {31'b0, e1}, 32'd0);
    set(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Narrow two-source sweep
    s_src[2][0] = 32'h15; s_src[2][1] = 32'h2A;
    for (int k = 0; k < 8; k++) begin
      set(2, 1'b0, 1'b0, 1'b1, 1'b1, k % 2); step();
      chk("tp_sweep_q", {26'b0, q2}, (k % 2) ? 32'h2A : 32'h15);
    end
    chk("tp_sweep_err", {31'b0, e2}, 32'd0);

    // Saturation over a long stall, then reset in the middle of it
    set(0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 254) chk("tp_sat_254", {24'b0, sc0}, 32'd254);
    end
    chk("tp_sat_255", {24'b0, sc0}, 32'd255);
    set(0, 1'b1, 1'b0, 1'b0, 1'b1, 1); step();
    chk("tp_sat_rst_cnt", {24'b0, sc0}, 32'd0);
    chk("tp_sat_rst_q", q0, 32'h0);
    chk("tp_sat_rst_valid", {31'b0, v0}, 32'd0);
    set(0, 1'b0, 1'b0, 1'b1, 1'b1, 3); step();
    chk("tp_post_rst_q", q0, 32'hDDDD_0003);

    // Random traffic on all instances
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 4; k++) s_src[i][k] = $urandom;
        set(i, ($urandom_range(99) < 3), ($urandom_range(99) < 10),
            ($urandom_range(99) < 70), $urandom_range(1),
            $urandom_range((1 << selw[i]) - 1));
      end
      step();
    end
    chk("u2_err_never", {31'b0, e2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
